// File: rtl/shreg_sched.sv
// shreg_sched: round-robin arbiter and load/shift sequencer for one shared
// universal shift register; all outputs registered.
module shreg_sched #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [CNTW-1:0]  cnt0,
    input  logic [CNTW-1:0]  cnt1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_pin,
    output logic             done,
    output logic             done_id
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_d;
    logic last, last_d, win, win_d, dir, dir_d, sel;
    logic gnt0_d, gnt1_d, busy_d, done_d, done_id_d;
    logic [CNTW-1:0] rem, rem_d;
    logic [1:0] mode_d;
    logic [WIDTH-1:0] pin_d;
    always_comb begin
        sel = (req0 && req1) ? ~last : req1;
        state_d = state;
        last_d = last;
        win_d = win;
        dir_d = dir;
        rem_d = rem;
        pin_d = sr_pin;
        gnt0_d = gnt0;
        gnt1_d = gnt1;
        busy_d = busy;
        mode_d = 2'b00;
        done_d = 1'b0;
        done_id_d = done_id;
        case (state)
            IDLE: if (req0 || req1) begin
                state_d = LOAD;
                last_d = sel;
                win_d = sel;
                dir_d = sel ? dir1 : dir0;
                rem_d = sel ? cnt1 : cnt0;
                pin_d = sel ? data1 : data0;
                gnt0_d = ~sel;
                gnt1_d = sel;
                busy_d = 1'b1;
                mode_d = 2'b11;
            end
            // rem holds the full count through LOAD; SHIFT counts it down to 1
            LOAD, SHIFT: if (rem == '0 || (state == SHIFT && rem == CNTW'(1))) begin
                state_d = DONE;
                done_d = 1'b1;
                done_id_d = win;
            end else begin
                state_d = SHIFT;
                mode_d = dir ? 2'b10 : 2'b01;
                if (state == SHIFT) rem_d = rem - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last <= 1'b1;
            win <= 1'b0;
            dir <= 1'b0;
            rem <= '0;
            sr_pin <= '0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
            sr_mode <= 2'b00;
            done <= 1'b0;
            done_id <= 1'b0;
        end else begin
            state <= state_d;
            last <= last_d;
            win <= win_d;
            dir <= dir_d;
            rem <= rem_d;
            sr_pin <= pin_d;
            gnt0 <= gnt0_d;
            gnt1 <= gnt1_d;
            busy <= busy_d;
            sr_mode <= mode_d;
            done <= done_d;
            done_id <= done_id_d;
        end
    end
endmodule

// File: tb/tb_shreg_sched.sv
// tb_shreg_sched: transaction-level model predicts grants and timing; a monitor
// rebuilds each transaction from the register-side pins and scores it.
module tb_shreg_sched;
    logic clk = 0, rst = 0, req0 = 0, req1 = 0, dir0 = 0, dir1 = 0;
    logic [3:0] data0 = 0, data1 = 0;
    logic [2:0] cnt0 = 0, cnt1 = 0;
    logic gnt0, gnt1, busy, done, done_id;
    logic [1:0] sr_mode;
    logic [3:0] sr_pin;

    typedef struct {
        logic id;
        logic [3:0] data;
        logic dir;
        int cnt;
        int k;
    } txn_t;
    txn_t exp[$];
    txn_t cur;
    int checks = 0, failures = 0, edges = 0, free_edge = 0, shifts = 0;
    logic last = 1'b1;
    bit inprog = 0, prev_done = 0;

    shreg_sched #(.WIDTH(4), .CNTW(3)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .dir0(dir0), .dir1(dir1),
        .cnt0(cnt0), .cnt1(cnt1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .sr_mode(sr_mode), .sr_pin(sr_pin), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Requester free once cnt+3 edges have passed since its capture edge.
    function automatic void predict();
        int k;
        logic id;
        k = edges + 1;
        if (k >= free_edge && (req0 || req1)) begin
            id = (req0 && req1) ? !last : req1;
            exp.push_back('{id, id ? data1 : data0, id ? dir1 : dir0,
                            id ? int'(cnt1) : int'(cnt0), k});
            last = id;
            free_edge = k + (id ? int'(cnt1) : int'(cnt0)) + 3;
        end
    endfunction

    task automatic drive(input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1,
                         input logic i0, input logic i1, input logic [2:0] c0, input logic [2:0] c1);
        @(negedge clk);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1;
        dir0 = i0; dir1 = i1; cnt0 = c0; cnt1 = c1;
        predict();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, data0, data1, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(gnt0 == 0 && gnt1 == 0, {tag, "_gnt"}, {gnt1, gnt0}, 0);
        chk(busy == 0, {tag, "_busy"}, busy, 0);
        chk(sr_mode == 0, {tag, "_mode"}, sr_mode, 0);
        chk(sr_pin == 0, {tag, "_pin"}, sr_pin, 0);
        chk(done == 0 && done_id == 0, {tag, "_done"}, {done, done_id}, 0);
    endtask

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            inprog = 0;
            prev_done = 0;
        end else begin
            if (prev_done) chk(busy == 0, "busy_after_done", busy, 0);
            chk(!(gnt0 && gnt1), "gnt_onehot", {gnt1, gnt0}, 1);
            if (sr_mode == 2'b11) begin
                if (inprog || exp.size() == 0) chk(0, "unexpected_load", edges, -1);
                else begin
                    cur = exp.pop_front();
                    inprog = 1;
                    shifts = 0;
                    chk(edges == cur.k, "load_edge", edges, cur.k);
                    chk(gnt0 == !cur.id && gnt1 == cur.id, "load_gnt", {gnt1, gnt0}, cur.id ? 2 : 1);
                    chk(sr_pin == cur.data, "load_data", sr_pin, cur.data);
                end
            end else if (sr_mode != 2'b00) begin
                shifts++;
                chk(inprog && sr_mode == (cur.dir ? 2'b10 : 2'b01), "shift_mode", sr_mode, cur.dir ? 2 : 1);
                chk(inprog && gnt0 == !cur.id && gnt1 == cur.id, "shift_gnt", {gnt1, gnt0}, cur.id ? 2 : 1);
            end
            if (done) begin
                if (!inprog) chk(0, "unexpected_done", 1, 0);
                else begin
                    chk(done_id == cur.id, "done_id", done_id, cur.id);
                    chk(shifts == cur.cnt, "shift_count", shifts, cur.cnt);
                    chk(edges == cur.k + cur.cnt + 1, "done_edge", edges, cur.k + cur.cnt + 1);
                    chk(sr_mode == 2'b00, "done_mode", sr_mode, 0);
                    chk(gnt0 == !cur.id && gnt1 == cur.id, "done_gnt", {gnt1, gnt0}, cur.id ? 2 : 1);
                end
                inprog = 0;
            end
            chk(busy == (inprog || done), "busy", busy, inprog || done);
            prev_done = done;
        end
    end

    initial begin
        #2 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1;
        // both requesting from reset: grants alternate starting with 0
        repeat (16) drive(1, 1, 4'h3, 4'hC, 0, 1, 3'd1, 3'd3);
        idle(8);
        drive(1, 0, 4'b1010, 4'h0, 0, 0, 3'd2, 3'd0);
        idle(6);
        drive(0, 1, 4'h0, 4'b0111, 0, 0, 3'd0, 3'd0);
        idle(4);
        // requester drops and data changes while its transaction runs
        drive(1, 0, 4'h6, 4'h0, 0, 0, 3'd4, 3'd0);
        repeat (8) drive(0, 0, 4'hF, 4'h0, 0, 0, 3'd4, 3'd0);
        drive(1, 0, 4'h9, 4'h0, 1, 0, 3'd7, 3'd0);
        idle(12);
        // reset in SHIFT with a tie pending
        drive(1, 0, 4'h5, 4'h0, 0, 0, 3'd6, 3'd0);
        drive(1, 1, 4'h5, 4'hA, 0, 1, 3'd2, 3'd1);
        drive(1, 1, 4'h5, 4'hA, 0, 1, 3'd2, 3'd1);
        #1 rst = 0;
        #1 check_reset_outputs("async_reset");
        #1;
        exp.delete();
        last = 1'b1;
        free_edge = 0;
        #1 rst = 1;
        predict();
        repeat (10) drive(1, 1, 4'h5, 4'hA, 0, 1, 3'd2, 3'd1);
        idle(6);
        repeat (400)
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
        for (int i = 0; i < 40 && (exp.size() != 0 || inprog); i++) idle(1);
        idle(2);
        chk(exp.size() == 0 && !inprog, "drain", exp.size() + int'(inprog), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
